mod_n_counter: RTL
==================

# mod_n_counter

Parametrised modulo-N counter for the digital clock datapath, replacing the fixed per-digit counters. Counts 0..MODULUS-1 when enabled and loads an adjust value when the user is setting the time. It emits a same-cycle terminal-count enable so that stages chain into seconds/minutes/hours without skew. It also emits a registered wrap pulse for display and alarm logic.

## Interface
- MODULUS, default 6: count range 0..MODULUS-1; legal range 2..256.
- WIDTH, default $clog2(MODULUS): count width; must satisfy 2^WIDTH >= MODULUS.
- clock  in  1  rising-edge clock, the only clock.
- reset_n  in  1  synchronous, active-low reset.
- load  in  1  adjust mode; when 1, count takes load_value.
- load_value  in  WIDTH  adjust value.
- count_en  in  1  count enable (1-cycle pulse from the prescaler or from the previous stage's tc).
- up  in  1  direction, 1 = up; ignored unless MOD_COUNTER_DOWN_EN.
- count  out  WIDTH  current value, registered.
- tc  out  1  combinational terminal count, the enable for the next stage.
- wrap  out  1  registered 1-cycle pulse following a wrap.

## Operation
- Priority per rising edge of clock: reset_n low, then load, then count_en, then hold.
- Reset (reset_n=0): count=0, wrap=0. tc is 0 because count_en is don't-care while in reset; gate tc with reset_n.
- Load (load=1): count <= min(load_value, MODULUS-1). Values at or above MODULUS clamp to MODULUS-1. wrap <= 0. tc forced 0 while load=1, so no carry is generated during adjust.
- Count, up (count_en=1, load=0):
  - count <= count+1.
  - At MODULUS-1, count <= 0 and wrap <= 1.
- Count, down (macro only, up=0):
  - count <= count-1.
  - At 0, count <= MODULUS-1 and wrap <= 1.
- Hold (count_en=0): count unchanged, wrap <= 0.
- tc = reset_n & ~load & count_en & (count == MODULUS-1 when counting up, count == 0 when counting down). Because tc is asserted in the same cycle as the wrapping edge, a chained stage advances on that same edge.
- Out-of-range state (count >= MODULUS, e.g. after a SEU): the next count step goes to 0 with wrap=1. tc stays 0 in that case.
- Arithmetic is done in WIDTH+1 bits internally; no silent modulo-2^WIDTH wrap is allowed.

## Timing
- count latency: 1 cycle from the count_en, load or reset_n sample.
- tc: zero latency, combinational from count, count_en, load, up and reset_n. No combinational path from load_value.
- wrap: high exactly one cycle, in the cycle after the wrapping edge. Back-to-back wraps (MODULUS=2 with count_en held high) give wrap high on consecutive cycles.
- Reset asserted mid-count overrides a simultaneous count_en or load. The first count can occur on the first edge after reset_n is sampled high.
- Simultaneous load and count_en: load wins, and tc is 0 in that cycle.
- Changing up while count_en=1 takes effect on that same edge.

## Configuration
- MOD_COUNTER_DOWN_EN defined: the up port selects direction, and the down wrap and down tc rules apply.
- Not defined: up is ignored and the count is up-only. No down-compare logic is synthesised. The port list is identical in both builds.

## Structure
- Shared package clock_pkg holds:
  - the per-digit modulus constants: SEC_ONES_MOD=10, SEC_TENS_MOD=6, MIN_ONES_MOD=10, MIN_TENS_MOD=6, HR_ONES_MOD=10, HR_TENS_MOD=3;
  - the counter width helper.
- No sub-module; the next-value and terminal-count logic live in one always block plus one assign.
- Cascading into a full clock chain is a separate wrapper, not part of this block.

## Test plan
- Reset: MODULUS=6, hold reset_n=0 with count_en=1 for 3 cycles -> count=0, wrap=0, tc=0. Release reset_n -> count=1 one cycle later.
- Up wrap: MODULUS=6, count_en held 1 from count=0 -> sequence 0,1,2,3,4,5,0. tc=1 only while count=5. wrap=1 only in the cycle count first reads 0.
- Load/clamp: load=1 with load_value=3 -> count=3. load_value=7 -> count=5. load=1 with count_en=1 at count=5 -> count=5, tc=0, wrap stays 0.
- Cascade: two instances, MODULUS=10 then 6, with the second stage's count_en tied to the first stage's tc. Drive 60 enable pulses -> second stage counts 0..5 and returns to 0 on the same edge as the first stage's 9->0 transition. Second-stage tc is high at 59.
- Down (macro defined): MODULUS=6, up=0, start at 1 -> 1,0,5,4. tc=1 at count=0. wrap is asserted after 0->5. Flip up=1 at count=4 -> next value is 5.
- Out-of-range: force count=7 with WIDTH=3 and MODULUS=6 -> next count_en gives count=0, wrap=1, tc=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the digital clock datapath: per-digit moduli and the
// counter width helper used to size mod_n_counter instances.
package clock_pkg;

  localparam int unsigned SEC_ONES_MOD = 10;
  localparam int unsigned SEC_TENS_MOD = 6;
  localparam int unsigned MIN_ONES_MOD = 10;
  localparam int unsigned MIN_TENS_MOD = 6;
  localparam int unsigned HR_ONES_MOD  = 10;
  localparam int unsigned HR_TENS_MOD  = 3;

  // Smallest width that holds 0..modulus-1; never less than one bit.
  function automatic int unsigned counter_width(input int unsigned modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N digit counter with adjust load, same-cycle terminal count and a
// registered wrap pulse. Define MOD_COUNTER_DOWN_EN to enable down counting.
module mod_n_counter
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS = 6,
  parameter int unsigned WIDTH   = counter_width(MODULUS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned     LAST_INT = MODULUS - 1;
  localparam logic [WIDTH:0]  LAST     = LAST_INT[WIDTH:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   count_inc;
  logic             at_last;
  logic             out_of_range;
  logic             dir_up;
  logic             term_hit;

  assign count_ext    = {1'b0, count_q};
  assign load_ext     = {1'b0, load_value};
  assign count_inc    = count_ext + 1'b1;
  assign at_last      = (count_ext == LAST);
  assign out_of_range = (count_ext > LAST);

`ifdef MOD_COUNTER_DOWN_EN
  logic [WIDTH:0] count_dec;
  logic           at_zero;
  logic           unused_bits;

  assign count_dec   = count_ext - 1'b1;
  assign at_zero     = (count_q == '0);
  assign dir_up      = up;
  assign unused_bits = ^{count_inc[WIDTH], count_dec[WIDTH]};
`else
  logic unused_bits;

  assign dir_up      = 1'b1;
  assign unused_bits = ^{count_inc[WIDTH], up};
`endif

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    term_hit = 1'b0;
    if (load) begin
      count_d = (load_ext > LAST) ? LAST[WIDTH-1:0] : load_value;
    end else if (count_en) begin
      // A corrupted (>= MODULUS) state recovers to 0 regardless of direction.
      if (out_of_range) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else if (dir_up) begin
        term_hit = at_last;
        if (at_last) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_inc[WIDTH-1:0];
        end
      end else begin
`ifdef MOD_COUNTER_DOWN_EN
        term_hit = at_zero;
        if (at_zero) begin
          count_d = LAST[WIDTH-1:0];
          wrap_d  = 1'b1;
        end else begin
          count_d = count_dec[WIDTH-1:0];
        end
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign tc    = reset_n & ~load & count_en & term_hit;
  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
